gray_rgb_serializer: RTL
========================

# gray_rgb_serializer

Output-side stage of the edge-detection datapath. Takes single-subpixel grayscale pixels from the processing pipeline over a valid/ready handshake and emits each as an RGB triplet, one subpixel per beat in R, G, B order, to the host-facing byte interface. It is the return path matching the RGB-to-grayscale front end. Each gray value is replicated into all three channels, so the host receives a standard RGB stream. Start-of-frame and end-of-frame are carried through a last flag.

## Interface

Parameters:
- P_SUBPIXEL_DEPTH, default 32'd8: width of one gray value and one output beat.
- P_PIXEL_DEPTH, local, equals 3 * P_SUBPIXEL_DEPTH: width of the equivalent RGB pixel. Documentation only; no port uses it.

Ports:
- I_CLK, input, 1: clock. The block has exactly one clock.
- I_RESET, input, 1: reset, asynchronous, active-high.
- I_PIXEL, input, P_SUBPIXEL_DEPTH: grayscale pixel.
- I_VALID, input, 1: I_PIXEL and I_LAST are valid.
- I_LAST, input, 1: this pixel is the final pixel of the frame.
- O_READY, output, 1: the block accepts a pixel at this edge.
- O_DATA, output, P_SUBPIXEL_DEPTH: current subpixel beat.
- O_CHANNEL, output, 2: channel of the current beat. 2'd0 = R, 2'd1 = G, 2'd2 = B. 2'd3 never occurs.
- O_VALID, output, 1: O_DATA, O_CHANNEL and O_LAST are valid.
- I_READY, input, 1: the downstream sink accepts the current beat.
- O_LAST, output, 1: asserted only on the B beat of a pixel that was accepted with I_LAST=1.

## Operation

Input handshake:
- A pixel is accepted on a rising edge where I_VALID=1 and O_READY=1.
- O_READY is combinational from registered state, gated by ~I_RESET. It never depends on I_VALID or I_READY.

Output handshake:
- A beat is consumed on a rising edge where O_VALID=1 and I_READY=1.
- While O_VALID=1 and I_READY=0, O_DATA, O_CHANNEL, O_VALID and O_LAST hold their values.

Beat state machine (S_IDLE, S_R, S_G, S_B):
- S_IDLE: O_VALID=0 and O_READY=1. When a pixel is accepted, latch the pixel and its last flag, then go to S_R.
- S_R: O_CHANNEL=0. When the beat is consumed, go to S_G.
- S_G: O_CHANNEL=1. When the beat is consumed, go to S_B.
- S_B: O_CHANNEL=2 and O_LAST = latched last flag. When the beat is consumed, go to the next state:
  - S_R if a pending pixel is available (skid buffer, see Configuration); that pixel is loaded.
  - S_IDLE otherwise.
- O_DATA equals the latched gray value in every beat state.
- O_VALID=1 in S_R, S_G and S_B.
- No arithmetic is performed. Widths are preserved exactly and no rounding is applied.

Boundary conditions:
- I_LAST has no effect on the state machine beyond driving O_LAST; consecutive frames stream without gaps.
- A pixel accepted with I_VALID=1 and I_LAST=1 is serialized normally and marks its B beat with O_LAST=1.
- Reset mid-pixel discards the active pixel and any pending pixel. No partial triplet is emitted after reset.

## Timing

Reset:
- Asynchronous. While I_RESET=1, the state is S_IDLE and O_DATA=0, O_CHANNEL=0, O_VALID=0, O_LAST=0, O_READY=0.
- After I_RESET deasserts, O_READY=1 from the first cycle.

Latency:
- A pixel accepted at edge N presents its R beat (O_VALID=1) in the cycle after edge N.
- With I_READY held at 1, the B beat is consumed at edge N+3.

Throughput with I_READY held at 1:
- Macro off: one pixel every 4 cycles.
- Macro on: one pixel every 3 cycles, i.e. O_VALID stays at 1 continuously.

## Configuration

Macro GRAY_RGB_SERIALIZER_SKID_EN enables a one-entry pending register (pixel plus last flag).
- Defined:
  - O_READY = ~pending_full.
  - A pixel accepted while the state machine is in S_IDLE loads directly into the active registers.
  - A pixel accepted in any other state fills the pending register.
  - When the B beat is consumed with the pending register full, the pending pixel moves to the active registers, the state goes to S_R, and the pending register clears.
  - If the B beat is consumed and a new pixel is accepted on the same edge with the pending register empty, the new pixel goes directly to S_R.
- Undefined: no pending register exists, O_READY=1 only in S_IDLE, and pixels are never accepted during beats.

## Test plan

- Reset: assert I_RESET asynchronously mid-G-beat. Required: O_VALID=0, O_READY=0 and O_DATA=0 immediately; after release, O_READY=1 and no B beat is emitted.
- Single pixel: I_PIXEL=8'hA5 with I_LAST=0 and I_READY=1. Required: beats (8'hA5,0), (8'hA5,1), (8'hA5,2) on three consecutive cycles, then O_VALID=0 and O_LAST=0 throughout.
- Backpressure: I_PIXEL=8'h3C, I_READY=0 for 5 cycles during the G beat. Required: O_DATA=8'h3C and O_CHANNEL=1 held stable; the B beat appears one cycle after I_READY returns to 1.
- Last flag: pixels 8'h01, 8'h02, 8'hFF with I_LAST=1 on 8'hFF. Required: O_LAST=1 only on the B beat of 8'hFF, and 9 beats total.
- Streaming: 16 pixels 0..15 with I_VALID and I_READY held at 1. Required: 48 in-order beats; 64 cycles with the macro off and 48 contiguous O_VALID cycles with the macro on.
- Skid full (macro on): hold I_READY=0 with one pixel active. Required: one extra pixel is accepted, then O_READY=0 until the active B beat is consumed; no pixel is lost or duplicated.

Source files
------------

// File: rtl/gray_rgb_serializer.sv
// rtl/gray_rgb_serializer.sv - grayscale pixel to R/G/B subpixel beat serializer
//
// Purpose: accepts one gray value per valid/ready handshake and replays it
// as three beats (R, G, B) on the output handshake. The pixel's last flag
// marks its B beat.
//
// Optional feature: define GRAY_RGB_SERIALIZER_SKID_EN to add a one-entry
// pending register so a new pixel can be taken while beats are in flight.
// With it undefined, pixels are only accepted in S_IDLE.
//
// Ports:
//   I_CLK      in   clock
//   I_RESET    in   asynchronous active-high reset
//   I_PIXEL    in   gray value, P_SUBPIXEL_DEPTH bits
//   I_VALID    in   I_PIXEL/I_LAST valid
//   I_LAST     in   final pixel of the frame
//   O_READY    out  pixel accepted on this edge when I_VALID=1
//   O_DATA     out  current subpixel beat
//   O_CHANNEL  out  0=R, 1=G, 2=B
//   O_VALID    out  O_DATA/O_CHANNEL/O_LAST valid
//   I_READY    in   sink consumes the current beat
//   O_LAST     out  B beat of a pixel accepted with I_LAST=1

module gray_rgb_serializer #(
    parameter int unsigned P_SUBPIXEL_DEPTH = 32'd8
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    input  logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL,
    input  logic                        I_VALID,
    input  logic                        I_LAST,
    output logic                        O_READY,
    output logic [P_SUBPIXEL_DEPTH-1:0] O_DATA,
    output logic [1:0]                  O_CHANNEL,
    output logic                        O_VALID,
    input  logic                        I_READY,
    output logic                        O_LAST
);

    // Width of the equivalent RGB pixel; not used by any port.
    localparam int unsigned P_PIXEL_DEPTH = 3 * P_SUBPIXEL_DEPTH;

    generate
        if (P_PIXEL_DEPTH < 3) begin : g_depth_check
            $error("P_SUBPIXEL_DEPTH must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_R    = 2'd1,
        S_G    = 2'd2,
        S_B    = 2'd3
    } state_t;

    state_t                      state_q;
    logic [P_SUBPIXEL_DEPTH-1:0] data_q;
    logic                        last_q;     // last flag of the active pixel
    logic                        valid_q;
    logic [1:0]                  chan_q;
    logic                        olast_q;    // last flag as presented on the B beat
    logic                        accept;
    logic                        consume;

`ifdef GRAY_RGB_SERIALIZER_SKID_EN
    logic [P_SUBPIXEL_DEPTH-1:0] pend_data_q;
    logic                        pend_last_q;
    logic                        pend_full_q;

    assign O_READY = ~I_RESET & ~pend_full_q;
`else
    assign O_READY = ~I_RESET & (state_q == S_IDLE);
`endif

    assign accept  = I_VALID & O_READY;
    assign consume = valid_q & I_READY;

    assign O_DATA    = data_q;
    assign O_CHANNEL = chan_q;
    assign O_VALID   = valid_q;
    assign O_LAST    = olast_q;

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            chan_q      <= 2'd0;
            olast_q     <= 1'b0;
`ifdef GRAY_RGB_SERIALIZER_SKID_EN
            pend_data_q <= '0;
            pend_last_q <= 1'b0;
            pend_full_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        data_q  <= I_PIXEL;
                        last_q  <= I_LAST;
                        valid_q <= 1'b1;
                        chan_q  <= 2'd0;
                        olast_q <= 1'b0;
                        state_q <= S_R;
                    end
                end
                S_R: begin
                    if (consume) begin
                        chan_q  <= 2'd1;
                        state_q <= S_G;
                    end
                end
                S_G: begin
                    if (consume) begin
                        chan_q  <= 2'd2;
                        olast_q <= last_q;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (consume) begin
                        chan_q  <= 2'd0;
                        olast_q <= 1'b0;
`ifdef GRAY_RGB_SERIALIZER_SKID_EN
                        if (pend_full_q) begin
                            data_q      <= pend_data_q;
                            last_q      <= pend_last_q;
                            pend_full_q <= 1'b0;
                            state_q     <= S_R;
                        end else if (accept) begin
                            // Pixel arriving on the closing edge bypasses the pending slot.
                            data_q  <= I_PIXEL;
                            last_q  <= I_LAST;
                            state_q <= S_R;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
`else
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase

`ifdef GRAY_RGB_SERIALIZER_SKID_EN
            // Accepts outside S_IDLE park in the pending slot, except the
            // bypass case handled in S_B above.
            if (accept && (state_q != S_IDLE) && !((state_q == S_B) && consume)) begin
                pend_data_q <= I_PIXEL;
                pend_last_q <= I_LAST;
                pend_full_q <= 1'b1;
            end
`endif
        end
    end

endmodule
